// File: rtl/bsg_tag_tx_pkg.sv
// Shared types, sizing macros and helpers for the bsg_tag serial packet transmitter.
// The header struct is provided as a macro so the RTL and the bench model share one layout.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif
`ifndef BSG_WIDTH
`define BSG_WIDTH(x) ($clog2((x) + 1))
`endif

// Header layout; node_id occupies the LSBs and is therefore transmitted first.
`define BSG_TAG_TX_HDR_S(lg_els, len_w) \
    typedef struct packed { \
        logic [(len_w)-1:0]  len; \
        logic                data_not_reset; \
        logic [(lg_els)-1:0] node_id; \
    } bsg_tag_tx_hdr_s;

package bsg_tag_tx_pkg;

    typedef enum logic [2:0] {
        e_idle,
        e_start,
        e_hdr,
        e_payload,
        e_gap
    } bsg_tag_tx_state_e;

    function automatic int unsigned hdr_width(input int unsigned lg_els, input int unsigned len_w);
        return lg_els + 1 + len_w;
    endfunction

endpackage

// File: rtl/bsg_tag_tx_piso.sv
// Parallel-in serial-out shifter for one tag frame; bit 0 of the loaded word leaves first.
// The counter tracks how many frame bits remain, including the one currently on bit_o.
module bsg_tag_tx_piso #(
    parameter int unsigned width_p     = 25,
    parameter int unsigned cnt_width_p = 5
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   load_i,
    input  logic [width_p-1:0]     data_i,
    input  logic [cnt_width_p-1:0] cnt_i,
    output logic                   bit_o,
    output logic [cnt_width_p-1:0] remaining_o
);

    logic [width_p-1:0]     sr_q;
    logic [cnt_width_p-1:0] cnt_q;

    // Zeros shift in behind the frame, so the line idles low once the frame is out.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            sr_q  <= data_i;
            cnt_q <= cnt_i;
        end else begin
            sr_q <= sr_q >> 1;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - cnt_width_p'(1);
            end
        end
    end

    assign bit_o       = sr_q[0];
    assign remaining_o = cnt_q;

endmodule

// File: rtl/bsg_tag_packet_tx.sv
// Serial bsg_tag packet transmitter: accepts one request, shifts start/header/payload out LSB first.
// Optional macro BSG_TAG_TX_COUNTER_EN adds pkt_count_o, a wrapping count of completed packets.
module bsg_tag_packet_tx
    import bsg_tag_tx_pkg::*;
#(
    parameter  int unsigned els_p               = 4,
    parameter  int unsigned max_payload_width_p = 16,
    parameter  int unsigned gap_cycles_p        = 2,
    localparam int unsigned lg_els_lp           = `BSG_SAFE_CLOG2(els_p),
    localparam int unsigned len_width_lp        = `BSG_WIDTH(max_payload_width_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           v_i,
    output logic                           ready_o,
    input  logic [lg_els_lp-1:0]           node_id_i,
    input  logic                           data_not_reset_i,
    input  logic [len_width_lp-1:0]        len_i,
    input  logic [max_payload_width_p-1:0] payload_i,
    output logic                           tag_data_o,
    output logic                           busy_o
`ifdef BSG_TAG_TX_COUNTER_EN
    ,
    output logic [15:0]                    pkt_count_o
`endif
);

    localparam int unsigned hdr_lp       = hdr_width(lg_els_lp, len_width_lp);
    localparam int unsigned frame_lp     = 1 + hdr_lp + max_payload_width_p;
    localparam int unsigned cnt_width_lp = `BSG_WIDTH(frame_lp);
    localparam int unsigned gap_width_lp = `BSG_SAFE_CLOG2(gap_cycles_p + 1);
    localparam int unsigned gap_load_lp  = (gap_cycles_p > 0) ? gap_cycles_p - 1 : 0;

    `BSG_TAG_TX_HDR_S(lg_els_lp, len_width_lp)

    bsg_tag_tx_state_e              state_q, state_n;
    logic [gap_width_lp-1:0]        gap_q, gap_n;
    logic [len_width_lp-1:0]        len_q, len_sat;
    logic                           ready_q, busy_q;
    logic                           accept, pkt_done;
    logic [max_payload_width_p-1:0] payload_mask;
    bsg_tag_tx_hdr_s                hdr;
    logic [frame_lp-1:0]            frame;
    logic [cnt_width_lp-1:0]        remaining;

    assign accept  = v_i & ready_q;
    assign len_sat = (len_i > len_width_lp'(max_payload_width_p))
                   ? len_width_lp'(max_payload_width_p) : len_i;

    // Frame assembly: payload bits at or above the saturated length are forced to zero.
    always_comb begin
        payload_mask = '0;
        for (int i = 0; i < int'(max_payload_width_p); i++) begin
            payload_mask[i] = (32'(len_sat) > 32'(i));
        end
        hdr                = '0;
        hdr.node_id        = node_id_i;
        hdr.data_not_reset = data_not_reset_i;
        hdr.len            = len_sat;
        frame              = {payload_i & payload_mask, hdr, 1'b1};
    end

    bsg_tag_tx_piso #(
        .width_p     (frame_lp),
        .cnt_width_p (cnt_width_lp)
    ) piso (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .load_i      (accept),
        .data_i      (frame),
        .cnt_i       (cnt_width_lp'(1 + hdr_lp) + cnt_width_lp'(len_sat)),
        .bit_o       (tag_data_o),
        .remaining_o (remaining)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
            gap_q   <= '0;
            len_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            gap_q   <= gap_n;
            ready_q <= (state_n == e_idle);
            busy_q  <= (state_n != e_idle);
            if (accept) begin
                len_q <= len_sat;
            end
        end
    end

    // Phase boundaries come from the shifter's remaining-bit count.
    always_comb begin
        state_n  = state_q;
        gap_n    = gap_q;
        pkt_done = 1'b0;
        case (state_q)
            e_idle:    if (accept) state_n = e_start;
            e_start:   state_n = e_hdr;
            e_hdr: begin
                if (remaining == cnt_width_lp'(len_q) + cnt_width_lp'(1)) begin
                    if (len_q != '0) state_n = e_payload;
                    else             pkt_done = 1'b1;
                end
            end
            e_payload: if (remaining == cnt_width_lp'(1)) pkt_done = 1'b1;
            e_gap: begin
                if (gap_q == '0) state_n = e_idle;
                else             gap_n = gap_q - gap_width_lp'(1);
            end
            default:   state_n = e_idle;
        endcase
        if (pkt_done) begin
            state_n = (gap_cycles_p == 0) ? e_idle : e_gap;
            gap_n   = gap_width_lp'(gap_load_lp);
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q | accept;

`ifdef BSG_TAG_TX_COUNTER_EN
    logic [15:0] pkt_count_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pkt_count_q <= '0;
        end else if (pkt_done) begin
            pkt_count_q <= pkt_count_q + 16'd1;
        end
    end

    assign pkt_count_o = pkt_count_q;
`endif

endmodule
